// File: rtl/pong_pkg.sv
// Shared definitions for the pong drawing path.
//
// Contents:
//   COORD_W, COLOR_W  - widths of a screen coordinate and of a pixel colour
//   draw_state_t      - arbiter state encoding (IDLE / ERASE / DRAW)
//   box_t             - box descriptor {x, y, w, h, color}
//   box_is_empty()    - true when a box covers no pixels (w == 0 or h == 0)
package pong_pkg;

    localparam int COORD_W = 9;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } draw_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
    } box_t;

    function automatic logic box_is_empty(input box_t b);
        return (b.w == '0) || (b.h == '0);
    endfunction

endpackage

// File: rtl/box_scanner.sv
// Row-major rasteriser for one box: emits one pixel per clock.
//
// A start pulse loads a box and the first pixel becomes visible on the
// outputs in the following cycle. The scan walks x from x0 to x0+w-1 and
// then moves down a row, finishing at (x0+w-1, y0+h-1). Positions are
// tracked in COORD_W+1 bits so a box hanging off the far edge of the
// coordinate space does not wrap back onto the screen.
//
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   start         - load box and begin scanning (a new start overrides a scan)
//   box           - box to scan; its color field is the pixel colour
//   pix_x, pix_y  - current scan position (low COORD_W bits)
//   pix_color     - colour for the current pixel
//   pix_plot      - current pixel is valid and inside the visible screen
//   last          - current pixel is the final one of the box
module box_scanner
    import pong_pkg::*;
#(
    parameter logic [COORD_W-1:0] SCREEN_WIDTH  = 9'd160,
    parameter logic [COORD_W-1:0] SCREEN_HEIGHT = 9'd120
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  box_t               box,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_plot,
    output logic               last
);

    logic [COORD_W:0]   cur_x;
    logic [COORD_W:0]   cur_y;
    logic [COORD_W:0]   x_start;
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic [COLOR_W-1:0] cur_color;
    logic               active_q;
    logic               plot_q;

    logic [COORD_W:0]   load_x;
    logic [COORD_W:0]   load_y;
    logic [COORD_W:0]   load_x_end;
    logic [COORD_W:0]   load_y_end;
    logic [COORD_W:0]   next_x;
    logic [COORD_W:0]   next_y;
    logic               at_row_end;

    // Clipped pixels still take their cycle; only the write strobe is
    // suppressed, so visibility is decided per pixel here.
    function automatic logic on_screen(input logic [COORD_W:0] px,
                                       input logic [COORD_W:0] py);
        return (px < {1'b0, SCREEN_WIDTH}) && (py < {1'b0, SCREEN_HEIGHT});
    endfunction

    // Box corners widened by one bit, and the step to the next pixel.
    always_comb begin
        load_x     = {1'b0, box.x};
        load_y     = {1'b0, box.y};
        load_x_end = load_x + {1'b0, box.w} - (COORD_W+1)'(1);
        load_y_end = load_y + {1'b0, box.h} - (COORD_W+1)'(1);
        at_row_end = (cur_x == x_end);
        next_x     = at_row_end ? x_start : cur_x + (COORD_W+1)'(1);
        next_y     = at_row_end ? cur_y + (COORD_W+1)'(1) : cur_y;
        last       = active_q && at_row_end && (cur_y == y_end);
    end

    // Scan position register. The start pulse has priority so the arbiter
    // can chain erase straight into draw without an idle cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x     <= '0;
            cur_y     <= '0;
            x_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            cur_color <= '0;
            active_q  <= 1'b0;
            plot_q    <= 1'b0;
        end else if (start) begin
            if (!box_is_empty(box)) begin
                cur_x     <= load_x;
                cur_y     <= load_y;
                x_start   <= load_x;
                x_end     <= load_x_end;
                y_end     <= load_y_end;
                cur_color <= box.color;
                active_q  <= 1'b1;
                plot_q    <= on_screen(load_x, load_y);
            end else begin
                active_q  <= 1'b0;
                plot_q    <= 1'b0;
            end
        end else if (active_q) begin
            if (last) begin
                active_q <= 1'b0;
                plot_q   <= 1'b0;
            end else begin
                cur_x  <= next_x;
                cur_y  <= next_y;
                plot_q <= on_screen(next_x, next_y);
            end
        end
    end

    assign pix_x     = cur_x[COORD_W-1:0];
    assign pix_y     = cur_y[COORD_W-1:0];
    assign pix_color = cur_color;
    assign pix_plot  = plot_q;

endmodule

// File: rtl/pong_draw_arbiter.sv
// Framebuffer write-port arbiter for the pong box producers.
//
// Grants one requester at a time in round-robin order, erases that
// requester's previously drawn box with the background colour, then draws
// the new box, one pixel per cycle through box_scanner.
//
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   req_valid      - per-requester descriptor valid
//   req_ready      - per-requester accept (one-hot or zero, combinational)
//   req_x/y/w/h    - packed per-requester box geometry, slice i = [9i+8:9i]
//   req_color      - packed per-requester box colour, slice i = [3i+2:3i]
//   bg_color       - erase colour, captured when a request is accepted
//   vga_x, vga_y   - pixel position
//   vga_color      - pixel colour
//   vga_plot       - framebuffer write strobe
//   busy           - high while erasing or drawing
module pong_draw_arbiter
    import pong_pkg::*;
#(
    parameter int                 NUM_REQ       = 3,
    parameter logic [COORD_W-1:0] SCREEN_WIDTH  = 9'd160,
    parameter logic [COORD_W-1:0] SCREEN_HEIGHT = 9'd120
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [COORD_W*NUM_REQ-1:0] req_x,
    input  logic [COORD_W*NUM_REQ-1:0] req_y,
    input  logic [COORD_W*NUM_REQ-1:0] req_w,
    input  logic [COORD_W*NUM_REQ-1:0] req_h,
    input  logic [COLOR_W*NUM_REQ-1:0] req_color,
    input  logic [COLOR_W-1:0]         bg_color,
    output logic [COORD_W-1:0]         vga_x,
    output logic [COORD_W-1:0]         vga_y,
    output logic [COLOR_W-1:0]         vga_color,
    output logic                       vga_plot,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    draw_state_t        state;
    draw_state_t        next_state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] has_prev;
    box_t               prev_box [NUM_REQ];
    box_t               cur_box;
    logic [IDX_W-1:0]   cur_idx;

    box_t               req_box [NUM_REQ];
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    box_t               sel_box;
    box_t               sel_prev;
    logic               sel_has_prev;
    logic               transfer;

    logic               scan_start;
    box_t               scan_box;
    logic               scan_last;
    logic               commit;
    box_t               commit_box;
    logic [IDX_W-1:0]   commit_idx;

    // Unpack the flat request buses into one descriptor per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_box[g] = {req_x[g*COORD_W +: COORD_W],
                             req_y[g*COORD_W +: COORD_W],
                             req_w[g*COORD_W +: COORD_W],
                             req_h[g*COORD_W +: COORD_W],
                             req_color[g*COLOR_W +: COLOR_W]};
    end

    // Round-robin grant: first valid requester at or after rr_ptr,
    // wrapping around. The winner's new and previous boxes are selected
    // here so the FSM sees them in the same cycle.
    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        cand_idx     = '0;
        grant_onehot = '0;
        sel_box      = '0;
        sel_prev     = '0;
        sel_has_prev = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found            = 1'b1;
                grant_idx              = cand_idx;
                grant_onehot[cand_idx] = 1'b1;
                sel_box                = req_box[cand_idx];
                sel_prev               = prev_box[cand_idx];
                sel_has_prev           = has_prev[cand_idx];
            end
        end
    end

    // Requests are only accepted in IDLE; anything presented while busy
    // simply waits and is never sampled.
    assign req_ready = (state == IDLE && !reset) ? grant_onehot : '0;
    assign transfer  = (state == IDLE) && !reset && grant_found;
    assign rr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : grant_idx + 1'b1;

    // Next-state and scanner control. An empty phase is skipped outright;
    // when the new box itself is empty the job completes immediately but
    // still records it as the requester's previous box.
    always_comb begin
        next_state = state;
        scan_start = 1'b0;
        scan_box   = '0;
        commit     = 1'b0;
        commit_box = cur_box;
        commit_idx = cur_idx;
        case (state)
            IDLE: begin
                if (transfer) begin
                    if (sel_has_prev && !box_is_empty(sel_prev)) begin
                        next_state     = ERASE;
                        scan_start     = 1'b1;
                        scan_box       = sel_prev;
                        scan_box.color = bg_color;
                    end else if (!box_is_empty(sel_box)) begin
                        next_state = DRAW;
                        scan_start = 1'b1;
                        scan_box   = sel_box;
                    end else begin
                        commit     = 1'b1;
                        commit_box = sel_box;
                        commit_idx = grant_idx;
                    end
                end
            end
            ERASE: begin
                if (scan_last) begin
                    if (!box_is_empty(cur_box)) begin
                        next_state = DRAW;
                        scan_start = 1'b1;
                        scan_box   = cur_box;
                    end else begin
                        next_state = IDLE;
                        commit     = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (scan_last) begin
                    next_state = IDLE;
                    commit     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, round-robin pointer, accepted job and per-requester history.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            has_prev <= '0;
            cur_box  <= '0;
            cur_idx  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                prev_box[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (transfer) begin
                cur_box <= sel_box;
                cur_idx <= grant_idx;
                rr_ptr  <= rr_next;
            end
            if (commit) begin
                prev_box[commit_idx] <= commit_box;
                has_prev[commit_idx] <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    box_scanner #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_scanner (
        .clock    (clock),
        .reset    (reset),
        .start    (scan_start),
        .box      (scan_box),
        .pix_x    (vga_x),
        .pix_y    (vga_y),
        .pix_color(vga_color),
        .pix_plot (vga_plot),
        .last     (scan_last)
    );

endmodule
